// File: rtl/toysram_pkg.sv
// ----------------------------------------------------------------------------
// toysram_pkg
// Shared geometry, types and helpers for the 16x12 toysram subarray controller.
//   ROWS/COLS/ADDR_W : subarray geometry
//   row_t            : row address
//   col_t            : one row of data (bit 0 = column 0)
//   wl_t             : one wordline bus (one bit per row)
//   ctl_state_t      : sequencer states
//   onehot16()       : row address to wordline pattern
// ----------------------------------------------------------------------------
package toysram_pkg;

    localparam int ROWS   = 16;
    localparam int COLS   = 12;
    localparam int ADDR_W = 4;

    typedef logic [ADDR_W-1:0] row_t;
    typedef logic [COLS-1:0]   col_t;
    typedef logic [ROWS-1:0]   wl_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RCV
    } ctl_state_t;

    // The macro's wordline bus is wired MSB-first: row 0 sits on bit 15 and
    // row 15 on bit 0, so the decode shifts a single bit down from the top.
    function automatic wl_t onehot16(input row_t addr);
        wl_t top;
        top = {1'b1, {(ROWS-1){1'b0}}};
        return top >> addr;
    endfunction

endpackage

// File: rtl/toysram_wl_drv.sv
// ----------------------------------------------------------------------------
// toysram_wl_drv
// Registered row decoder for one wordline bus. When en is high the flop takes
// the one-hot pattern of addr; otherwise the bus is pulled low on the next
// edge. Reset clears the bus immediately.
//   clk   in   clock
//   rst_n in   asynchronous reset, active low
//   en    in   drive the selected row on the next edge
//   addr  in   row to select
//   wl    out  registered one-hot (or all-zero) wordline bus
// ----------------------------------------------------------------------------
module toysram_wl_drv
    import toysram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROWS-1:0]   wl
);

    // Wordlines must come straight from a flop so the macro never sees
    // decoder glitches; reset drops the bus without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wl <= '0;
        end else if (en) begin
            wl <= onehot16(addr);
        end else begin
            wl <= '0;
        end
    end

endmodule

// File: rtl/toysram_16x12_ctl.sv
// ----------------------------------------------------------------------------
// toysram_16x12_ctl
// Access sequencer for one 16x12 toysram subarray (2 read ports, 1 write port).
// One command (up to two reads and one write) is taken per access; reads are
// performed first, then the write, then a one-cycle recovery with all
// wordlines and write bitlines low.
//
// Parameters:
//   RD_CYC  cycles the read wordlines are held before the capture cycle (>=1)
//   WR_CYC  cycles the write wordline is held with bitlines driven (>=1)
//   RBL_INV 1 when the macro's read bitlines are active-low
//
// Optional feature macro: TOYSRAM_CTL_BYPASS_EN
//   defined   : a read to the same row as the command's write returns wr_data
//   undefined : such a read returns the array contents before the write
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rd0_val/rd0_addr      read port 0 request
//   rd1_val/rd1_addr      read port 1 request
//   wr_val/wr_addr/wr_data write request
//   cmd_rdy               idle, command accepted when any *_val is high
//   rd0_dval/rd0_data     port 0 result strobe and held data
//   rd1_dval/rd1_data     port 1 result strobe and held data
//   RWL0, RWL1, WWL       registered wordlines to the macro
//   WBL, WBLb             write bitline pair to the macro
//   RBL0, RBL1            read bitlines from the macro
// ----------------------------------------------------------------------------
module toysram_16x12_ctl
    import toysram_pkg::*;
#(
    parameter int RD_CYC  = 2,
    parameter int WR_CYC  = 1,
    parameter int RBL_INV = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd0_val,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic              rd1_val,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic              wr_val,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COLS-1:0]   wr_data,
    output logic              cmd_rdy,
    output logic              rd0_dval,
    output logic [COLS-1:0]   rd0_data,
    output logic              rd1_dval,
    output logic [COLS-1:0]   rd1_data,
    output logic [ROWS-1:0]   RWL0,
    output logic [ROWS-1:0]   RWL1,
    output logic [ROWS-1:0]   WWL,
    output logic [COLS-1:0]   WBL,
    output logic [COLS-1:0]   WBLb,
    input  logic [COLS-1:0]   RBL0,
    input  logic [COLS-1:0]   RBL1
);

    localparam int CNT_MAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    ctl_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic  accept;
    logic  l_rd0_val, l_rd1_val, l_wr_val;
    row_t  l_rd0_addr, l_rd1_addr, l_wr_addr;
    col_t  l_wr_data;

    logic  cur_rd0_val, cur_rd1_val;
    row_t  cur_rd0_addr, cur_rd1_addr, cur_wr_addr;
    col_t  cur_wr_data;

    logic  rwl0_en, rwl1_en, wwl_en;
    col_t  rbl0_data, rbl1_data, rd0_cap, rd1_cap;

    assign cmd_rdy = (state == ST_IDLE);
    assign accept  = cmd_rdy && (rd0_val || rd1_val || wr_val);

    // The wordline flops are loaded on the same edge that takes the command,
    // so while idle the decoders look at the live request and afterwards at
    // the latched copy.
    always_comb begin
        cur_rd0_val  = l_rd0_val;
        cur_rd0_addr = l_rd0_addr;
        cur_rd1_val  = l_rd1_val;
        cur_rd1_addr = l_rd1_addr;
        cur_wr_addr  = l_wr_addr;
        cur_wr_data  = l_wr_data;
        if (state == ST_IDLE) begin
            cur_rd0_val  = rd0_val;
            cur_rd0_addr = rd0_addr;
            cur_rd1_val  = rd1_val;
            cur_rd1_addr = rd1_addr;
            cur_wr_addr  = wr_addr;
            cur_wr_data  = wr_data;
        end
    end

    // State register and phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: reads first, then the write, then recovery. Phases that the
    // command does not need are skipped. The wordline enables follow the
    // state being entered so each bus rises exactly with its phase; read and
    // write phases never share a state, so WWL cannot overlap RWL0/RWL1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (rd0_val || rd1_val) begin
                        state_nxt = ST_RD;
                        cnt_nxt   = CNT_W'(RD_CYC - 1);
                    end else begin
                        state_nxt = ST_WR;
                        cnt_nxt   = CNT_W'(WR_CYC - 1);
                    end
                end
            end
            ST_RD: begin
                if (cnt == '0) begin
                    state_nxt = ST_CAP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_CAP: begin
                if (l_wr_val) begin
                    state_nxt = ST_WR;
                    cnt_nxt   = CNT_W'(WR_CYC - 1);
                end else begin
                    state_nxt = ST_RCV;
                end
            end
            ST_WR: begin
                if (cnt == '0) begin
                    state_nxt = ST_RCV;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_RCV: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        rwl0_en = ((state_nxt == ST_RD) || (state_nxt == ST_CAP)) && cur_rd0_val;
        rwl1_en = ((state_nxt == ST_RD) || (state_nxt == ST_CAP)) && cur_rd1_val;
        wwl_en  = (state_nxt == ST_WR);
    end

    // Command latch; the fields stay stable for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_rd0_val  <= 1'b0;
            l_rd0_addr <= '0;
            l_rd1_val  <= 1'b0;
            l_rd1_addr <= '0;
            l_wr_val   <= 1'b0;
            l_wr_addr  <= '0;
            l_wr_data  <= '0;
        end else if (accept) begin
            l_rd0_val  <= rd0_val;
            l_rd0_addr <= rd0_addr;
            l_rd1_val  <= rd1_val;
            l_rd1_addr <= rd1_addr;
            l_wr_val   <= wr_val;
            l_wr_addr  <= wr_addr;
            l_wr_data  <= wr_data;
        end
    end

    toysram_wl_drv u_rwl0 (.clk(clk), .rst_n(rst_n), .en(rwl0_en), .addr(cur_rd0_addr), .wl(RWL0));
    toysram_wl_drv u_rwl1 (.clk(clk), .rst_n(rst_n), .en(rwl1_en), .addr(cur_rd1_addr), .wl(RWL1));
    toysram_wl_drv u_wwl  (.clk(clk), .rst_n(rst_n), .en(wwl_en),  .addr(cur_wr_addr),  .wl(WWL));

    // Write bitlines are registered alongside WWL so both pairs are valid
    // for the whole write pulse and released together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WBL  <= '0;
            WBLb <= '0;
        end else if (wwl_en) begin
            WBL  <= cur_wr_data;
            WBLb <= ~cur_wr_data;
        end else begin
            WBL  <= '0;
            WBLb <= '0;
        end
    end

    // Bitline polarity correction, then the optional same-row forwarding.
    always_comb begin
        rbl0_data = (RBL_INV != 0) ? ~RBL0 : RBL0;
        rbl1_data = (RBL_INV != 0) ? ~RBL1 : RBL1;
        rd0_cap   = rbl0_data;
        rd1_cap   = rbl1_data;
`ifdef TOYSRAM_CTL_BYPASS_EN
        if (l_wr_val && (l_rd0_addr == l_wr_addr)) begin
            rd0_cap = l_wr_data;
        end
        if (l_wr_val && (l_rd1_addr == l_wr_addr)) begin
            rd1_cap = l_wr_data;
        end
`endif
    end

    // Read bitlines are sampled at the end of the capture cycle while the
    // wordlines are still up; the strobes last exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_dval <= 1'b0;
            rd0_data <= '0;
            rd1_dval <= 1'b0;
            rd1_data <= '0;
        end else begin
            rd0_dval <= 1'b0;
            rd1_dval <= 1'b0;
            if (state == ST_CAP) begin
                if (l_rd0_val) begin
                    rd0_dval <= 1'b1;
                    rd0_data <= rd0_cap;
                end
                if (l_rd1_val) begin
                    rd1_dval <= 1'b1;
                    rd1_data <= rd1_cap;
                end
            end
        end
    end

endmodule
